// File: rtl/alu.sv
// Two's-complement add/sub/and/xor ALU with a registered condition-code set (ZF/SF/OF).
// Output/Overflow are combinational (0 cycles); flags appear 1 cycle after a set_cc edge; no backpressure.
module alu #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             S0,
   input  logic             S1,
   input  logic             set_cc,
   output logic [WIDTH-1:0] Output,
   output logic             Overflow,
   output logic             ZF,
   output logic             SF,
   output logic             OF
);

   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_t;

   op_t              op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             zero;

   assign op   = op_t'({S1, S0});
   assign sum  = A + B;
   assign diff = A - B;

   // Signed overflow: operands' signs compatible with overflow, and result sign flipped away from A.
   assign add_ovf = (A[MSB] == B[MSB]) && (sum[MSB]  != A[MSB]);
   assign sub_ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);

   always_comb begin
      Output   = '0;
      Overflow = 1'b0;
      unique case (op)
         OP_ADD: begin
            Output   = sum;
            Overflow = add_ovf;
         end
         OP_SUB: begin
            Output   = diff;
            Overflow = sub_ovf;
         end
         OP_AND: Output = A & B;
         OP_XOR: Output = A ^ B;
         default: begin
            Output   = '0;
            Overflow = 1'b0;
         end
      endcase
   end

   assign zero = (Output == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ZF <= 1'b0;
         SF <= 1'b0;
         OF <= 1'b0;
      end else if (set_cc) begin
         ZF <= zero;
         SF <= Output[MSB];
         OF <= Overflow;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu at WIDTH=64: combinational result/overflow and registered flags.
module tb_alu;

   localparam int W = 64;
   localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
   localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] A, B;
   logic         S0, S1, set_cc;
   logic [W-1:0] Output;
   logic         Overflow, ZF, SF, OF;

   int n_checks = 0;
   int n_fail   = 0;

   alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .S0(S0), .S1(S1), .set_cc(set_cc),
      .Output(Output), .Overflow(Overflow), .ZF(ZF), .SF(SF), .OF(OF)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s, input logic cc);
      A      = a;
      B      = b;
      {S1, S0} = s;
      set_cc = cc;
      #1;
   endtask

   task automatic flags(input string tag, input logic zf, input logic sf, input logic of);
      chk({tag, "_zf"}, {63'd0, ZF}, {63'd0, zf});
      chk({tag, "_sf"}, {63'd0, SF}, {63'd0, sf});
      chk({tag, "_of"}, {63'd0, OF}, {63'd0, of});
   endtask

   task automatic edge_then_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(64'd5, 64'd3, 2'b00, 1'b1);
      // Reset state, and combinational path alive during reset
      flags("reset", 1'b0, 1'b0, 1'b0);
      chk("add_in_reset", Output, 64'd8);
      edge_then_sample();
      flags("reset_over_setcc", 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      // Add 5+3
      drive(64'd5, 64'd3, 2'b00, 1'b1);
      chk("add_out", Output, 64'd8);
      chk("add_ovf", {63'd0, Overflow}, 64'd0);
      edge_then_sample();
      flags("add_flags", 1'b0, 1'b0, 1'b0);

      // Subtract
      @(negedge clk);
      drive(64'd100, 64'd8, 2'b01, 1'b0);
      chk("sub_out", Output, 64'd92);
      chk("sub_ovf", {63'd0, Overflow}, 64'd0);
      @(negedge clk);
      drive(64'd3, 64'd3, 2'b01, 1'b1);
      chk("sub_zero_out", Output, 64'd0);
      edge_then_sample();
      flags("sub_zero_flags", 1'b1, 1'b0, 1'b0);

      // Hold with set_cc=0 while inputs produce a very different result
      @(negedge clk);
      drive(MAXP, 64'd1, 2'b00, 1'b0);
      chk("add_ovf_out", Output, MINN);
      chk("add_ovf_flag", {63'd0, Overflow}, 64'd1);
      edge_then_sample();
      flags("hold", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      set_cc = 1'b1;
      edge_then_sample();
      flags("add_ovf_flags", 1'b0, 1'b1, 1'b1);

      // More overflow boundaries
      @(negedge clk);
      drive(MINN, 64'd1, 2'b01, 1'b0);
      chk("sub_min_out", Output, MAXP);
      chk("sub_min_ovf", {63'd0, Overflow}, 64'd1);
      drive(MAXP, ONES, 2'b01, 1'b0);
      chk("sub_max_m1_out", Output, MINN);
      chk("sub_max_m1_ovf", {63'd0, Overflow}, 64'd1);
      drive(ONES, 64'd1, 2'b00, 1'b0);
      chk("add_m1_p1_out", Output, 64'd0);
      chk("add_m1_p1_ovf", {63'd0, Overflow}, 64'd0);
      drive(MINN, MINN, 2'b00, 1'b0);
      chk("add_min_min_out", Output, 64'd0);
      chk("add_min_min_ovf", {63'd0, Overflow}, 64'd1);
      drive(MINN, ONES, 2'b01, 1'b0);
      chk("sub_min_m1_ovf", {63'd0, Overflow}, 64'd0);

      // Logic ops never overflow
      drive(64'hF0F0, 64'hFF00, 2'b10, 1'b0);
      chk("and_out", Output, 64'hF000);
      chk("and_ovf", {63'd0, Overflow}, 64'd0);
      drive(64'hF0F0, 64'hFF00, 2'b11, 1'b0);
      chk("xor_out", Output, 64'h0FF0);
      chk("xor_ovf", {63'd0, Overflow}, 64'd0);
      drive(MAXP, 64'd1, 2'b10, 1'b0);
      chk("and_noovf_out", Output, 64'd1);
      chk("and_noovf", {63'd0, Overflow}, 64'd0);
      drive(MINN, 64'd1, 2'b11, 1'b0);
      chk("xor_noovf_out", Output, 64'h8000_0000_0000_0001);
      chk("xor_noovf", {63'd0, Overflow}, 64'd0);

      // Negative result
      @(negedge clk);
      drive(64'd2, 64'd5, 2'b01, 1'b1);
      chk("neg_out", Output, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("neg_ovf", {63'd0, Overflow}, 64'd0);
      edge_then_sample();
      flags("neg_flags", 1'b0, 1'b1, 1'b0);

      // Capture OF without SF, then asynchronous mid-cycle reset
      @(negedge clk);
      drive(MINN, 64'd1, 2'b01, 1'b1);
      edge_then_sample();
      flags("sub_min_flags", 1'b0, 1'b0, 1'b1);
      drive(64'd2, 64'd5, 2'b01, 1'b1);
      edge_then_sample();
      flags("pre_reset", 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      flags("async_reset", 1'b0, 1'b0, 1'b0);
      chk("out_during_reset", Output, 64'hFFFF_FFFF_FFFF_FFFD);
      edge_then_sample();
      flags("reset_hold", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(64'd7, 64'd7, 2'b11, 1'b1);
      edge_then_sample();
      flags("post_reset_capture", 1'b1, 1'b0, 1'b0);

      // X-free outputs for every select code
      for (int s = 0; s < 4; s++) begin
         drive(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, s[1:0], 1'b0);
         chk("xfree", {62'd0, $isunknown(Output), $isunknown(Overflow)}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
